// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reusable for any pad input that needs to be brought into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw push-button and emits a one-cycle pulse per debounced press.
// The debounced level only follows the synchronized input after DEBOUNCE_CYCLES consecutive disagreeing samples.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic button_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (button_in),
    .q_out (sync_q)
  );

  // Any sample that agrees with the debounced level restarts the count,
  // so bounces never accumulate toward a level change.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pulse_d = ~stable_q & stable_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign button_out = pulse_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4: each step drives one
// clock edge and checks button_out 1 ns after it against a hand-derived value.
module tb_button_debounce;

  logic clk;
  logic reset;
  logic button_in;
  logic button_out;

  int vectors;
  int miscompares;

  button_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .button_in  (button_in),
    .button_out (button_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic b, input logic r, input logic exp, input string tag, input int k);
    button_in = b;
    reset     = r;
    @(posedge clk);
    #1;
    vectors++;
    assert (button_out === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: button_out=%b expected %b", tag, k, button_out, exp);
    end
    $display("vec %0d %s[%0d] in=%b rst=%b out=%b", vectors, tag, k, b, r, button_out);
  endtask

  // Hold a level for n edges; a pulse is expected only after edge pulse_at (-1 for none).
  task automatic hold(input logic b, input int n, input int pulse_at, input string tag);
    for (int k = 0; k < n; k++) begin
      step(b, 1'b0, (k == pulse_at), tag, k);
    end
  endtask

  initial begin
    logic [8:0] bounce;
    vectors     = 0;
    miscompares = 0;
    button_in   = 1'b1;
    reset       = 1'b1;

    // Reset held with the button pressed: no pulse, then one pulse 5 edges after release.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, "reset_hold", k);
    hold(1'b1, 12, 5, "post_reset");
    hold(1'b0, 8, -1, "release_a");

    // Clean press held for 20 cycles.
    hold(1'b1, 20, 5, "clean_press");
    hold(1'b0, 8, -1, "release_b");

    // Bounce 1,0,1,1,0,1,1,1,0 then steady high: pulse 5 edges into the final run.
    bounce = 9'b0_1110_1101;
    for (int k = 0; k < 9; k++) step(bounce[k], 1'b0, 1'b0, "bounce", k);
    hold(1'b1, 16, 5, "bounce_hold");
    hold(1'b0, 8, -1, "release_c");

    // Three-cycle glitch never changes the debounced level.
    hold(1'b1, 3, -1, "glitch_hi");
    hold(1'b0, 12, -1, "glitch_lo");
    vectors++;
    assert (dut.stable_q === 1'b0) else begin
      miscompares++;
      $error("FAIL glitch_stable: stable_q=%b expected 0", dut.stable_q);
    end

    // Release and re-press: two pulses, none on release.
    hold(1'b1, 10, 5, "press_1");
    hold(1'b0, 10, -1, "release_1");
    hold(1'b1, 10, 5, "press_2");
    hold(1'b0, 8, -1, "release_d");

    // Reset mid-count discards progress; full latency restarts after reset.
    hold(1'b1, 3, -1, "pre_reset");
    step(1'b1, 1'b1, 1'b0, "mid_reset", 0);
    hold(1'b1, 12, 5, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
